demux_2x1_reg: RTL

Registered 1-to-2 demultiplexer for the lab board. It routes a switch-driven data field into one of two hold registers, A or B, chosen by a select bit, on a debounced strobe (push-button/switch). It also provides per-channel update pulses and write counters for LED/LCD display. It is the write-side counterpart of the 2:1 LED selector, sitting between SWI and the LED/LCD outputs in top.

---
 rtl/demux_2x1_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/demux_2x1_reg.sv
// Registered 1-to-2 demultiplexer. It debounces a strobe, routes din into
// hold register A or B, pulses upd_a/upd_b and counts writes per channel.
//
// Ports:
//   clk_2      system clock
//   reset_n    asynchronous active-low reset
//   din        data to route (NBITS wide)
//   sel        destination: 1 = channel A, 0 = channel B
//   strobe     raw asynchronous write request
//   out_a      hold register A
//   out_b      hold register B
//   upd_a      one-cycle pulse when A is written
//   upd_b      one-cycle pulse when B is written
//   cnt_a      write counter for A (NCNT wide)
//   cnt_b      write counter for B (NCNT wide)
//   busy       high whenever the FSM is not in IDLE
//
// Build option: when DEMUX_SAT_EN is defined, the write counters saturate
// at all-ones. When it is not defined, they wrap to zero.
module demux_2x1_reg #(
    parameter int NBITS    = 2,
    parameter int DEBOUNCE = 4,
    parameter int NCNT     = 4
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [NBITS-1:0] din,
    input  logic             sel,
    input  logic             strobe,
    output logic [NBITS-1:0] out_a,
    output logic [NBITS-1:0] out_b,
    output logic             upd_a,
    output logic             upd_b,
    output logic [NCNT-1:0]  cnt_a,
    output logic [NCNT-1:0]  cnt_b,
    output logic             busy
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WRITE,
        WAIT_REL
    } state_t;

    state_t          state;
    logic            sync1;
    logic            strobe_s;
    logic [CW-1:0]   db_cnt;
    logic [NCNT-1:0] cnt_a_nxt;
    logic [NCNT-1:0] cnt_b_nxt;

`ifdef DEMUX_SAT_EN
    // The counter holds at all-ones. Later writes still update the data.
    always_comb begin
        cnt_a_nxt = (&cnt_a) ? cnt_a : cnt_a + NCNT'(1);
        cnt_b_nxt = (&cnt_b) ? cnt_b : cnt_b + NCNT'(1);
    end
`else
    always_comb begin
        cnt_a_nxt = cnt_a + NCNT'(1);
        cnt_b_nxt = cnt_b + NCNT'(1);
    end
`endif

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sync1    <= 1'b0;
            strobe_s <= 1'b0;
            db_cnt   <= '0;
            out_a    <= '0;
            out_b    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            upd_a    <= 1'b0;
            upd_b    <= 1'b0;
        end else begin
            sync1    <= strobe;
            strobe_s <= sync1;
            upd_a    <= 1'b0;
            upd_b    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (strobe_s) begin
                        state  <= ARM;
                        db_cnt <= '0;
                    end
                end
                ARM: begin
                    if (!strobe_s) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        // din and sel are sampled only on this edge.
                        state <= WRITE;
                        if (sel) begin
                            out_a <= din;
                            cnt_a <= cnt_a_nxt;
                            upd_a <= 1'b1;
                        end else begin
                            out_b <= din;
                            cnt_b <= cnt_b_nxt;
                            upd_b <= 1'b1;
                        end
                    end else begin
                        db_cnt <= db_cnt + CW'(1);
                    end
                end
                WRITE: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    // Holding the strobe gives exactly one write.
                    if (!strobe_s) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
